wb_trace_buffer: RTL
====================

# wb_trace_buffer

Commit-trace capture block for the single-cycle CPU. It watches the CPU's per-cycle writeback and store signals: `pc`, `r3_wr`, `r3_addr`, `r3_din`, `we`, `ram_a`, and the store data. Each architecturally visible event becomes one record in an on-chip FIFO. A host-side reader (UART bridge or LED stepper) drains the FIFO over a valid/ready handshake, so a program run can be checked against a golden trace in hardware instead of by waveform inspection.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `PC_W`, 8: CPU pc width.
- `DATA_W`, 32: register/store data width.

Ports:
- `clk`, in, 1: the single clock, shared with the CPU.
- `rst`, in, 1: synchronous, active-high reset.
- `cap_en`, in, 1: capture enable; signals are sampled only when it is 1.
- `pc`, in, PC_W: pc of the instruction committing this cycle.
- `r3_wr`, in, 1: register-file write enable.
- `r3_addr`, in, 5: destination register.
- `r3_din`, in, DATA_W: register write data.
- `we`, in, 1: data-RAM write enable.
- `ram_a`, in, 6: data-RAM word address.
- `ram_din`, in, DATA_W: store data.
- `tr_valid`, out, 1: head record available.
- `tr_ready`, in, 1: reader accepts the head record.
- `tr_data`, out, 2+PC_W+6+DATA_W: record `{ovf, kind, pc, addr[5:0], data}`.
- `tr_count`, out, clog2(DEPTH)+1: occupancy.
- `drop_cnt`, out, 8: events lost; saturates at 255.

## Operation
Event generation, evaluated each cycle with `cap_en`=1:
- REG event: `r3_wr`=1 and `r3_addr`≠0. Record has kind=0, addr={1'b0,r3_addr}, data=r3_din.
- STORE event: `we`=1. Record has kind=1, addr=ram_a, data=ram_din.
- Writes to r0 are never recorded.
- Both events in the same cycle: only the STORE record is pushed. The REG event counts as one drop.

Push and pop:
- The FIFO is first-word-fall-through. `tr_data` always shows the head entry while `tr_valid`=1.
- Pop occurs when `tr_valid` and `tr_ready` are both 1.
- Push while full is refused. The event counts as one drop and sets the sticky `ovf_pend`.
- The next accepted record carries ovf=1, and that push clears `ovf_pend`.
- Full with a simultaneous pop and push: both happen, no drop, `tr_count` unchanged.
- Empty with a push: `tr_valid` rises the next cycle. Records never bypass the FIFO.
- `drop_cnt` increments by at most 1 per cycle and holds at 255.
- `tr_ready` while `tr_valid`=0 is ignored.

Reset (`rst`=1 at a clock edge), including in the middle of a run:
- FIFO is flushed and `ovf_pend` is cleared.
- Outputs: `tr_valid`=0, `tr_data`=0, `tr_count`=0, `drop_cnt`=0.
- Events sampled in the reset cycle are discarded.

## Timing
- Capture latency: an event sampled at edge N appears on `tr_data`/`tr_valid` after edge N (visible in cycle N+1).
- Pop: the head advances at the accepting edge, and the next record is visible in the following cycle.
- Throughput: one push and one pop per cycle, sustained.
- `tr_count` and `drop_cnt` are registered and reflect all pushes, pops and drops of the prior edge.
- Every output is registered or derived from a single register. There is no combinational path from `tr_ready` to `tr_valid`.

## Configuration
- `TRACE_STORE_EN` defined: STORE events are captured as described above.
- Undefined: `we`, `ram_a` and `ram_din` are ignored and no kind=1 record is produced. A cycle with both events pushes the REG record and drops nothing. Port list and record width are unchanged.

## Structure
- Shared package `trace_pkg` holds:
  - `KIND_REG`=0, `KIND_STORE`=1;
  - field widths and the record width;
  - the `trace_rec_t` packed struct;
  - `DROP_MAX`=255.
- Sub-module `trace_fifo`: synchronous FWFT FIFO, parameterised by width and depth, with a count output. It has wrapping read/write pointers one bit wider than the index.
- The top level holds event decode, priority, `ovf_pend`, and the drop counter.

## Test plan
- **Single REG event:** after reset, `cap_en`=1, `r3_wr`=1, `r3_addr`=5, `r3_din`=0x0000_00AB, `pc`=0x04 for 1 cycle. Next cycle `tr_valid`=1 with `tr_data`={0,0,0x04,0x05,0x0000_00AB}, and `tr_count`=1.
- **r0 filter and STORE:** `r3_addr`=0 with `r3_wr`=1 pushes nothing. Then `we`=1, `ram_a`=0x3F, `ram_din`=0xDEADBEEF, `pc`=0x10 gives a kind=1 record with addr=0x3F.
- **Overflow:** `tr_ready`=0, 20 consecutive REG events with DEPTH=16. Result is `tr_count`=16 and `drop_cnt`=4. After one pop and one new event, that record has ovf=1.
- **Full plus simultaneous push/pop:** FIFO full, `tr_ready`=1 and one event in the same cycle. `tr_count` stays 16, `drop_cnt` is unchanged, and records pop in order.
- **Collision and saturation:** `r3_wr` and `we` in the same cycle push one STORE record and set `drop_cnt`=1. Separately, 300 overflow drops leave `drop_cnt`=255.
- **Reset mid-run:** with 7 records queued, assert `rst` for 1 cycle. Result is `tr_valid`=0, `tr_count`=0, `drop_cnt`=0, and the next event yields ovf=0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace buffer: record kinds,
// field widths, the default record layout and the drop ceiling.
package trace_pkg;

    localparam logic KIND_REG   = 1'b0;
    localparam logic KIND_STORE = 1'b1;

    localparam int OVF_W     = 1;
    localparam int KIND_W    = 1;
    localparam int ADDR_W    = 6;
    localparam int RADDR_W   = 5;
    localparam int TR_PC_W   = 8;
    localparam int TR_DATA_W = 32;
    localparam int REC_W     = OVF_W + KIND_W + TR_PC_W + ADDR_W + TR_DATA_W;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        logic                 ovf;
        logic                 kind;
        logic [TR_PC_W-1:0]   pc;
        logic [ADDR_W-1:0]    addr;
        logic [TR_DATA_W-1:0] data;
    } trace_rec_t;

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Trace read-out handshake: head record, its valid flag and the
// reader's ready. master = trace buffer, slave = host-side reader.
interface wb_trace_buffer_if #(
    parameter int REC_W = trace_pkg::REC_W
);
    logic             tr_valid;
    logic             tr_ready;
    logic [REC_W-1:0] tr_data;

    modport master (output tr_valid, output tr_data, input tr_ready);
    modport slave  (input tr_valid, input tr_data, output tr_ready);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Ports: push/din/push_ok (write), pop/dout/valid (read), full, count.
module trace_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     push_ok,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign valid   = (r_count != '0);
    assign full    = (r_count == FULL_CNT);
    assign count   = r_count;
    assign dout    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_pop   = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            // Cleared so the head reads as zero after reset.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!push_ok && w_pop) r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/wb_trace_buffer.sv
// Commit-trace capture: turns CPU register writes and stores into
// records {ovf, kind, pc, addr, data} queued for a host reader.
// Ports: clk, rst (sync, active-high), cap_en, pc, r3_wr/r3_addr/r3_din,
// we/ram_a/ram_din, tr (master handshake), tr_count, drop_cnt.
// Macro TRACE_STORE_EN: capture store events (else stores ignored).
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 8,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en,
    input  logic [PC_W-1:0]        pc,
    input  logic                   r3_wr,
    input  logic [4:0]             r3_addr,
    input  logic [DATA_W-1:0]      r3_din,
    input  logic                   we,
    input  logic [5:0]             ram_a,
    input  logic [DATA_W-1:0]      ram_din,
    wb_trace_buffer_if.master      tr,
    output logic [$clog2(DEPTH):0] tr_count,
    output logic [7:0]             drop_cnt
);
    localparam int RW = OVF_W + KIND_W + PC_W + ADDR_W + DATA_W;

    logic          w_reg_ev;
    logic          w_st_ev;
    logic          w_push;
    logic          w_push_ok;
    logic          w_lost;
    logic          w_full;
    logic [RW-1:0] w_rec;
    logic          r_ovf_pend;
    logic [7:0]    r_drop;

    assign w_reg_ev = cap_en && r3_wr && (r3_addr != 5'd0);

`ifdef TRACE_STORE_EN
    assign w_st_ev = cap_en && we;

    // A store wins over a same-cycle register write.
    always_comb begin
        w_rec = {r_ovf_pend, KIND_REG, pc, 1'b0, r3_addr, r3_din};
        if (w_st_ev) w_rec = {r_ovf_pend, KIND_STORE, pc, ram_a, ram_din};
    end
`else
    logic w_unused;
    assign w_unused = ^{we, ram_a, ram_din};
    assign w_st_ev  = 1'b0;

    always_comb begin
        w_rec = {r_ovf_pend, KIND_REG, pc, 1'b0, r3_addr, r3_din};
    end
`endif

    assign w_push = w_reg_ev || w_st_ev;
    // Collision loss and full-FIFO refusal never coincide as two drops.
    assign w_lost = (w_reg_ev && w_st_ev) || (w_push && !w_push_ok);

    trace_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .din     (w_rec),
        .push_ok (w_push_ok),
        .pop     (tr.tr_ready),
        .dout    (tr.tr_data),
        .valid   (tr.tr_valid),
        .full    (w_full),
        .count   (tr_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_pend <= 1'b0;
            r_drop     <= '0;
        end else begin
            if (w_push_ok)   r_ovf_pend <= 1'b0;
            else if (w_push) r_ovf_pend <= 1'b1;
            if (w_lost && r_drop != DROP_MAX) r_drop <= r_drop + 1'b1;
        end
    end

    assign drop_cnt = r_drop;

    logic w_unused_full;
    assign w_unused_full = w_full;
endmodule
